// File: rtl/p2_seq_pkg.sv
// Shared types and constants for the problem2 vector sequencer.
// Result words are {X,AB,AC}. Vector index i holds bits [3i+2:3i] of an expected table.
package p2_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_VEC = 8;
   localparam int VEC_W = 3;
   localparam int RES_W = 3;

   localparam int F_X  = 2;
   localparam int F_AB = 1;
   localparam int F_AC = 0;

   function automatic logic [RES_W-1:0] exp_entry(
      input logic [N_VEC*RES_W-1:0] tbl,
      input logic [VEC_W-1:0]       idx
   );
      return tbl[RES_W*int'(idx) +: RES_W];
   endfunction

endpackage

// File: rtl/p2_result_table.sv
// 8 x 3 capture table for the problem2 response.
// Synchronous write and clear, asynchronous reset, combinational read.
module p2_result_table
   import p2_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [VEC_W-1:0] wr_idx,
   input  logic [RES_W-1:0] wr_data,
   input  logic [VEC_W-1:0] rd_idx,
   output logic [RES_W-1:0] rd_data
);

   logic [RES_W-1:0] mem [N_VEC];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_VEC; i++) mem[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < N_VEC; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/p2_vector_sequencer.sv
// Clocked, restartable stimulus/capture sequencer for the problem2 block.
// state | meaning
// IDLE  | stimulus parked at 000, waiting for start
// RUN   | stepping vectors 0..7, each held DWELL cycles, capturing on the last
// DONE  | run complete, results held, pass valid
module p2_vector_sequencer
   import p2_seq_pkg::*;
#(
   parameter int                       DWELL     = 10,
   parameter logic [N_VEC*RES_W-1:0]   EXP_TABLE = 24'h000000
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             A,
   output logic             B,
   output logic             C,
   input  logic             x_in,
   input  logic             ab_in,
   input  logic             ac_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       mismatch_cnt,
   output logic             first_fail_valid,
   output logic [VEC_W-1:0] first_fail_idx,
   input  logic [VEC_W-1:0] rd_idx,
   output logic [RES_W-1:0] rd_data
);

   localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
   localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(N_VEC - 1);

   state_t           state_q, state_d;
   logic [VEC_W-1:0] vec;
   logic [7:0]       dcnt;
   logic             launch, capture, last_dwell, miss;
   logic [RES_W-1:0] res;

   always_comb begin
      res       = '0;
      res[F_X]  = x_in;
      res[F_AB] = ab_in;
      res[F_AC] = ac_in;
   end

   assign last_dwell = (dcnt == DWELL_LAST);
   assign miss       = (res != exp_entry(EXP_TABLE, vec));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // abort overrides everything, including a same-cycle start or final capture
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      capture = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d = RUN;
                  launch  = 1'b1;
               end
            end
            RUN: begin
               if (last_dwell) begin
                  capture = 1'b1;
                  if (vec == VEC_LAST) state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec              <= '0;
         dcnt             <= '0;
         mismatch_cnt     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else begin
         if (launch) begin
            vec              <= '0;
            dcnt             <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
         end else if (state_q == RUN && !abort) begin
            if (last_dwell) begin
               dcnt <= '0;
               if (vec != VEC_LAST) vec <= vec + 1'b1;
            end else begin
               dcnt <= dcnt + 8'd1;
            end
         end
         if (capture && miss) begin
            mismatch_cnt <= mismatch_cnt + 4'd1;
            if (!first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_idx   <= vec;
            end
         end
      end
   end

   p2_result_table u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (launch),
      .wr_en   (capture),
      .wr_idx  (vec),
      .wr_data (res),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign pass      = done && (mismatch_cnt == 4'd0);
   assign {A, B, C} = busy ? vec : '0;

endmodule

// File: tb/tb_p2_vector_sequencer.sv
// Self-checking bench: a reference problem2 model drives the responses,
// expected stimulus/table values are queued and popped as the DUT produces them.
module tb_p2_vector_sequencer;

   localparam logic [23:0] GOLD = 24'hFA8000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, abort;
   logic       a, b, c, x_in, ab_in, ac_in, busy, done, pass, ffv;
   logic [3:0] mcnt;
   logic [2:0] ffi, rd_idx, rd_data;
   logic [7:0] inj_mask;

   logic       start1, abort1;
   logic       a1, b1, c1, x1, ab1, ac1, busy1, done1, pass1, ffv1;
   logic [3:0] mcnt1;
   logic [2:0] ffi1, rd_idx1, rd_data1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] sb_q[$];
   logic [3:0] exp_v;

   // reference problem2: AB = A&B, AC = A&C, X = AB|AC
   function automatic logic [2:0] p2_model(input logic [2:0] v);
      logic ab_m, ac_m;
      ab_m = v[2] & v[1];
      ac_m = v[2] & v[0];
      return {ab_m | ac_m, ab_m, ac_m};
   endfunction

   logic [2:0] resp, resp1;
   always_comb begin
      resp = p2_model({a, b, c});
      if (inj_mask[{a, b, c}]) resp[2] = ~resp[2];
      resp1 = p2_model({a1, b1, c1});
   end
   assign {x_in, ab_in, ac_in} = resp;
   assign {x1, ab1, ac1}       = resp1;

   p2_vector_sequencer #(.DWELL(10), .EXP_TABLE(GOLD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .A(a), .B(b), .C(c), .x_in(x_in), .ab_in(ab_in), .ac_in(ac_in),
      .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mcnt),
      .first_fail_valid(ffv), .first_fail_idx(ffi),
      .rd_idx(rd_idx), .rd_data(rd_data)
   );

   p2_vector_sequencer #(.DWELL(1), .EXP_TABLE(GOLD)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .A(a1), .B(b1), .C(c1), .x_in(x1), .ab_in(ab1), .ac_in(ac1),
      .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mcnt1),
      .first_fail_valid(ffv1), .first_fail_idx(ffi1),
      .rd_idx(rd_idx1), .rd_data(rd_data1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; inj_mask = '0;
      start1 = 1'b0; abort1 = 1'b0; rd_idx = '0; rd_idx1 = '0;
      repeat (3) step();
      n_cmp++;
      if ({busy, done, pass, a, b, c, ffv, mcnt, ffi} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_state got %b want 0", {busy, done, pass, a, b, c, ffv, mcnt, ffi});
      end
      @(negedge clk) rst_n = 1'b1;
      step();
      inj_mask = 8'hFF;
      pulse_start();
      repeat (34) step();
      n_cmp++;
      if (rd_data !== 3'b100 || mcnt !== 4'd3) begin
         n_bad++;
         $display("FAIL pre_reset_capture got %b/%0d want 100/3", rd_data, mcnt);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, pass, a, b, c, ffv, mcnt, ffi} !== 13'd0) begin
         n_bad++;
         $display("FAIL async_reset got %b want 0", {busy, done, pass, a, b, c, ffv, mcnt, ffi});
      end
      for (int i = 0; i < 8; i++) sb_q.push_back(4'd0);
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i);
         #1;
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({1'b0, rd_data} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_table[%0d] got %b want %b", i, rd_data, exp_v[2:0]);
         end
      end
      inj_mask = '0;
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   task automatic test_golden();
      for (int v = 0; v < 8; v++) repeat (10) sb_q.push_back({1'b1, 3'(v)});
      pulse_start();
      for (int k = 0; k < 80; k++) begin
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({busy, a, b, c} !== exp_v) begin
            n_bad++;
            $display("FAIL golden_stim cyc %0d got %b want %b", k + 1, {busy, a, b, c}, exp_v);
         end
         step();
      end
      n_cmp++;
      if ({busy, done, pass, a, b, c, ffv} !== 7'b0110000 || mcnt !== 4'd0) begin
         n_bad++;
         $display("FAIL golden_done got %b cnt %0d want 0110000 cnt 0", {busy, done, pass, a, b, c, ffv}, mcnt);
      end
      for (int i = 0; i < 8; i++) sb_q.push_back({1'b0, p2_model(3'(i))});
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i);
         #1;
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({1'b0, rd_data} !== exp_v) begin
            n_bad++;
            $display("FAIL golden_table[%0d] got %b want %b", i, rd_data, exp_v[2:0]);
         end
      end
   endtask

   task automatic test_fault();
      inj_mask = 8'h20;
      pulse_start();
      repeat (80) step();
      n_cmp++;
      if ({done, pass, ffv} !== 3'b101 || mcnt !== 4'd1 || ffi !== 3'd5) begin
         n_bad++;
         $display("FAIL fault_result got done/pass/ffv %b cnt %0d idx %0d want 101 1 5", {done, pass, ffv}, mcnt, ffi);
      end
      rd_idx = 3'd5;
      #1;
      n_cmp++;
      if (rd_data !== 3'b001) begin
         n_bad++;
         $display("FAIL fault_table5 got %b want 001", rd_data);
      end
      inj_mask = '0;
   endtask

   task automatic test_handshake();
      int cnt;
      pulse_start();
      rd_idx = 3'd5;
      #1;
      n_cmp++;
      if ({busy, done, ffv} !== 3'b100 || mcnt !== 4'd0 || rd_data !== 3'b000) begin
         n_bad++;
         $display("FAIL restart_clear got %b cnt %0d tbl %b want 100 0 000", {busy, done, ffv}, mcnt, rd_data);
      end
      cnt = 0;
      for (int k = 0; k < 200 && busy; k++) begin
         start = (k == 39);
         step();
         cnt++;
      end
      start = 1'b0;
      n_cmp++;
      if (cnt != 80 || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL start_in_run got %0d cycles pass %b want 80 1", cnt, pass);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_cmp++;
      if ({busy, done, pass} !== 3'b000) begin
         n_bad++;
         $display("FAIL abort_from_done got %b want 000", {busy, done, pass});
      end
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      step();
      n_cmp++;
      if ({busy, done, a, b, c} !== 5'b0) begin
         n_bad++;
         $display("FAIL start_abort_same got %b want 00000", {busy, done, a, b, c});
      end
   endtask

   task automatic test_abort();
      inj_mask = 8'hFF;
      pulse_start();
      repeat (34) step();
      n_cmp++;
      if ({busy, a, b, c} !== 4'b1011) begin
         n_bad++;
         $display("FAIL abort_pre got %b want 1011", {busy, a, b, c});
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_cmp++;
      if ({busy, done, pass, a, b, c} !== 6'b0 || mcnt !== 4'd3 || {ffv, ffi} !== 4'b1000) begin
         n_bad++;
         $display("FAIL abort_post got %b cnt %0d ff %b want 0 3 1000", {busy, done, pass, a, b, c}, mcnt, {ffv, ffi});
      end
      for (int i = 0; i < 8; i++)
         sb_q.push_back((i < 3) ? {1'b0, p2_model(3'(i)) ^ 3'b100} : 4'd0);
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i);
         #1;
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({1'b0, rd_data} !== exp_v) begin
            n_bad++;
            $display("FAIL abort_table[%0d] got %b want %b", i, rd_data, exp_v[2:0]);
         end
      end
      inj_mask = '0;
      step();
   endtask

   task automatic test_dwell1();
      for (int v = 0; v < 8; v++) sb_q.push_back({1'b1, 3'(v)});
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         exp_v = sb_q.pop_front();
         n_cmp++;
         if ({busy1, a1, b1, c1} !== exp_v) begin
            n_bad++;
            $display("FAIL dwell1_stim cyc %0d got %b want %b", k + 1, {busy1, a1, b1, c1}, exp_v);
         end
         step();
      end
      n_cmp++;
      if ({busy1, done1, pass1, a1, b1, c1} !== 6'b011000 || mcnt1 !== 4'd0) begin
         n_bad++;
         $display("FAIL dwell1_done got %b cnt %0d want 011000 0", {busy1, done1, pass1, a1, b1, c1}, mcnt1);
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_fault();
      test_handshake();
      test_abort();
      test_dwell1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
